bpb_resolver: RTL and testbench

BPB_RESOLVER -- requirements
Module: bpb_resolver

---
 rtl/bpb_pkg.sv | 26 ++
 rtl/bpb.svh | 5 +
 rtl/bpb_resolver_fifo.sv | 52 +++++
 rtl/bpb_resolver.sv | 97 +++++++++
 tb/tb_bpb_resolver.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bpb_pkg.sv
// Branch-predictor types: BHT 2-bit counter states, in-flight queue entry, resolver FSM.
`include "bpb.svh"

package bpb_pkg;
    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_state_e;

    typedef struct packed {
        logic [`BPB_T-1:0] index;
        bht_state_e        state;
    } bq_entry_t;

    typedef enum logic {
        RSV_RUN      = 1'b0,
        RSV_REDIRECT = 1'b1
    } rsv_state_e;

    // The counter's upper bit is the taken/not-taken prediction.
    function automatic logic pred_taken(bht_state_e s);
        return s[1];
    endfunction
endpackage

// File: rtl/bpb.svh
// Shared branch-predictor defines: default BHT index width.
`ifndef BPB_SVH
`define BPB_SVH
`define BPB_T 8
`endif

// File: rtl/bpb_resolver_fifo.sv
// In-order queue of in-flight predicted branches with push, pop and flush.
module bpb_resolver_fifo
    import bpb_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  bq_entry_t            push_data_i,
    output bq_entry_t            head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_WIDTH:0] count_o
);
    localparam int DEPTH = 1 << DEPTH_WIDTH;

    bq_entry_t              mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_WIDTH:0]   count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Flush drops the head and everything younger in one step.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + 1'b1;
            if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr] <= push_data_i;
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;
    assign full_o  = (count == (DEPTH_WIDTH+1)'(DEPTH));
    assign empty_o = (count == '0);
endmodule

// File: rtl/bpb_resolver.sv
// Resolves in-flight branch predictions and issues BHT update requests.
// Optional BPB_RESOLVER_STATS_EN adds resolve/mispredict counters.
`include "bpb.svh"

module bpb_resolver
    import bpb_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2,
    parameter int INDEX_WIDTH = `BPB_T
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   push_i,
    input  logic [INDEX_WIDTH-1:0] push_index_i,
    input  logic [1:0]             push_state_i,
    input  logic                   resolve_i,
    input  logic                   resolve_taken_i,
    output logic                   update_en_o,
    output logic                   last_taken_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   mispredict_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [DEPTH_WIDTH:0]   count_o,
    output logic [31:0]            resolve_cnt_o,
    output logic [31:0]            mispredict_cnt_o
);
    rsv_state_e state;
    bq_entry_t  push_entry, head;
    logic       q_full, q_empty;
    logic       pop_acc, push_acc, mispred;

    assign pop_acc  = en_i && resolve_i && !q_empty;
    assign mispred  = pop_acc && (resolve_taken_i != pred_taken(head.state));
    // A pop in the same cycle frees a slot; a mispredict discards the push.
    assign push_acc = en_i && push_i && (state == RSV_RUN) && (!q_full || pop_acc) && !mispred;

    assign push_entry.index = `BPB_T'(push_index_i);
    assign push_entry.state = bht_state_e'(push_state_i);

    bpb_resolver_fifo #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push_acc),
        .pop_i       (pop_acc),
        .flush_i     (mispred),
        .push_data_i (push_entry),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (count_o)
    );

    assign empty_o = q_empty;
    assign full_o  = q_full || (state == RSV_REDIRECT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= RSV_RUN;
            update_en_o    <= 1'b0;
            last_taken_o   <= 1'b0;
            update_index_o <= '0;
            mispredict_o   <= 1'b0;
        end else if (!en_i) begin
            update_en_o  <= 1'b0;
            mispredict_o <= 1'b0;
        end else begin
            update_en_o  <= pop_acc;
            mispredict_o <= mispred;
            if (pop_acc) begin
                last_taken_o   <= resolve_taken_i;
                update_index_o <= INDEX_WIDTH'(head.index);
            end
            case (state)
                RSV_RUN:      if (mispred) state <= RSV_REDIRECT;
                RSV_REDIRECT: state <= RSV_RUN;
                default:      state <= RSV_RUN;
            endcase
        end
    end

`ifdef BPB_RESOLVER_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resolve_cnt_o    <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            if (pop_acc) resolve_cnt_o    <= resolve_cnt_o + 1'b1;
            if (mispred) mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
        end
    end
`else
    assign resolve_cnt_o    = '0;
    assign mispredict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_bpb_resolver.sv
// Directed bench for bpb_resolver: hand-computed expectations per scenario.
module tb_bpb_resolver;
    logic        clk = 1'b0;
    logic        rst_n, en, push, resolve, taken;
    logic [7:0]  push_idx;
    logic [1:0]  push_st;
    logic        upd_en, last_taken, misp, full, empty;
    logic [7:0]  upd_idx;
    logic [2:0]  count;
    logic [31:0] res_cnt, misp_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bpb_resolver #(.DEPTH_WIDTH(2), .INDEX_WIDTH(8)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .en_i             (en),
        .push_i           (push),
        .push_index_i     (push_idx),
        .push_state_i     (push_st),
        .resolve_i        (resolve),
        .resolve_taken_i  (taken),
        .update_en_o      (upd_en),
        .last_taken_o     (last_taken),
        .update_index_o   (upd_idx),
        .mispredict_o     (misp),
        .full_o           (full),
        .empty_o          (empty),
        .count_o          (count),
        .resolve_cnt_o    (res_cnt),
        .mispredict_cnt_o (misp_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic p, input logic [7:0] idx, input logic [1:0] st,
                       input logic r, input logic t);
        push = p; push_idx = idx; push_st = st; resolve = r; taken = t;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_cnt"},   32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"},  32'(full), 0);
        chk({tag, "_upd"},   32'(upd_en), 0);
        chk({tag, "_misp"},  32'(misp), 0);
        chk({tag, "_last"},  32'(last_taken), 0);
        chk({tag, "_idx"},   32'(upd_idx), 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        drv(0, 0, 0, 0, 0);
        step(); step();
        chk_reset_outs("rst");
        rst_n = 1'b1;
        step();

        // Correct taken prediction
        drv(1, 8'd5, 2'b11, 0, 0); step();
        chk("t1_cnt1", 32'(count), 1);
        drv(0, 0, 0, 1, 1); step();
        chk("t1_upd", 32'(upd_en), 1);
        chk("t1_idx", 32'(upd_idx), 5);
        chk("t1_last", 32'(last_taken), 1);
        chk("t1_misp", 32'(misp), 0);
        chk("t1_cnt0", 32'(count), 0);
        drv(0, 0, 0, 0, 0); step();
        chk("t1_pulse", 32'(upd_en), 0);

        // Mispredict then REDIRECT cycle
        drv(1, 8'd3, 2'b01, 0, 0); step();
        drv(0, 0, 0, 1, 1); step();
        chk("t2_misp", 32'(misp), 1);
        chk("t2_idx", 32'(upd_idx), 3);
        chk("t2_cnt", 32'(count), 0);
        chk("t2_full_redir", 32'(full), 1);
        drv(1, 8'd7, 2'b10, 0, 0); step();
        chk("t2_redir_drop", 32'(count), 0);
        chk("t2_misp_pulse", 32'(misp), 0);
        chk("t2_full_run", 32'(full), 0);
        step();
        chk("t2_push_ok", 32'(count), 1);
        drv(0, 0, 0, 1, 1); step();
        chk("t2_idx7", 32'(upd_idx), 7);
        chk("t2_misp7", 32'(misp), 0);

        // Resolve while empty
        drv(0, 0, 0, 1, 0); step();
        chk("t4_upd", 32'(upd_en), 0);
        chk("t4_cnt", 32'(count), 0);
        chk("t4_last", 32'(last_taken), 1);

        // Fill, drop, push+pop while full
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'(10 + i), 2'b11, 0, 0); step();
        end
        chk("t3_full", 32'(full), 1);
        chk("t3_cnt4", 32'(count), 4);
        drv(1, 8'd14, 2'b11, 0, 0); step();
        chk("t3_drop", 32'(count), 4);
        drv(1, 8'd15, 2'b11, 1, 1); step();
        chk("t3_pp_cnt", 32'(count), 4);
        chk("t3_pp_idx", 32'(upd_idx), 10);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, 1); step();
            chk($sformatf("t3_order%0d", i), 32'(upd_idx), (i < 3) ? 32'(11 + i) : 32'd15);
        end
        chk("t3_empty", 32'(empty), 1);

        // Flush of younger entries, then mid-queue reset
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'(20 + i), 2'b00, 0, 0); step();
        end
        drv(0, 0, 0, 1, 1); step();
        chk("t5_misp", 32'(misp), 1);
        chk("t5_idx", 32'(upd_idx), 20);
        chk("t5_cnt", 32'(count), 0);
        chk("t5_empty", 32'(empty), 1);
        drv(0, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'(40 + i), 2'b11, 0, 0); step();
        end
        drv(0, 0, 0, 1, 1); step();
        chk("t5_pre_rst", 32'(upd_en), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("t5_rst");
        @(negedge clk) rst_n = 1'b1;
        drv(0, 0, 0, 1, 1); step();
        chk("t5_no_upd", 32'(upd_en), 0);
        chk("t5_cnt_after", 32'(count), 0);

        // Enable low holds state
        drv(1, 8'd30, 2'b11, 0, 0); step();
        drv(1, 8'd31, 2'b11, 0, 0); step();
        drv(0, 0, 0, 1, 1); step();
        chk("t6_idx30", 32'(upd_idx), 30);
        en = 1'b0;
        drv(1, 8'd50, 2'b00, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_hold_cnt%0d", i), 32'(count), 1);
            chk($sformatf("t6_hold_upd%0d", i), 32'(upd_en), 0);
            chk($sformatf("t6_hold_idx%0d", i), 32'(upd_idx), 30);
            chk($sformatf("t6_hold_last%0d", i), 32'(last_taken), 1);
        end
        en = 1'b1;
        drv(0, 0, 0, 1, 1); step();
        chk("t6_idx31", 32'(upd_idx), 31);
        chk("t6_cnt0", 32'(count), 0);

        // Statistics: 10 resolves, first 3 mispredicted
        rst_n = 1'b0; step(); rst_n = 1'b1;
        drv(0, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            drv(1, 8'(60 + i), 2'b11, 0, 0); step();
            drv(0, 0, 0, 1, (i >= 3)); step();
            drv(0, 0, 0, 0, 0); step();
        end
`ifdef BPB_RESOLVER_STATS_EN
        chk("st_res", res_cnt, 10);
        chk("st_misp", misp_cnt, 3);
`else
        chk("st_res_zero", res_cnt, 0);
        chk("st_misp_zero", misp_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
